// File: rtl/ps2_host_transmitter_if.sv
// Command-side handshake of the PS/2 host transmitter.
// Master issues start/tx_data; slave reports busy and completion pulses.
`timescale 1ns/1ps
interface ps2_host_transmitter_if;
  logic       start;
  logic [7:0] tx_data;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output start, tx_data,
    input  busy, tx_done, tx_error
  );

  modport slave (
    input  start, tx_data,
    output busy, tx_done, tx_error
  );
endinterface

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 command transmitter over open-drain ps2c/ps2d.
// Define PS2TX_ACK_CHECK_EN to turn a missing device ACK into tx_error.
`timescale 1ns/1ps
module ps2_host_transmitter #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic clock,
  input  logic reset,
  ps2_host_transmitter_if.slave host,
  input  logic ps2c_in,
  input  logic ps2d_in,
  output logic ps2c_oe,
  output logic ps2d_oe
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_ACK,
    S_WAIT_IDLE, S_DONE, S_ERROR
  } state_t;

  state_t state;

  logic c_s1, c_s2, d_s1, d_s;
  logic [FILTER_LEN-1:0] c_sr;
  logic c_filt, fall;

  logic [9:0]    sh;
  logic [3:0]    idx;
  logic [IW-1:0] icnt;
  logic [TW-1:0] tcnt;
  logic busy_q, done_q, err_q;

  assign host.busy     = busy_q;
  assign host.tx_done  = done_q;
  assign host.tx_error = err_q;

  // Filtered clock only moves once every sample in the window agrees.
  always_ff @(posedge clock) begin
    if (reset) begin
      c_s1   <= 1'b1;
      c_s2   <= 1'b1;
      d_s1   <= 1'b1;
      d_s    <= 1'b1;
      c_sr   <= '1;
      c_filt <= 1'b1;
      fall   <= 1'b0;
    end else begin
      c_s1 <= ps2c_in;
      c_s2 <= c_s1;
      d_s1 <= ps2d_in;
      d_s  <= d_s1;
      c_sr <= {c_sr[FILTER_LEN-2:0], c_s2};
      fall <= 1'b0;
      if (&c_sr) begin
        c_filt <= 1'b1;
      end else if (~|c_sr) begin
        c_filt <= 1'b0;
        fall   <= c_filt;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      ps2c_oe <= 1'b0;
      ps2d_oe <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sh      <= '0;
      idx     <= '0;
      icnt    <= '0;
      tcnt    <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          ps2c_oe <= 1'b0;
          ps2d_oe <= 1'b0;
          state   <= S_IDLE;
          if (host.start) begin
            sh      <= {1'b1, ~^host.tx_data, host.tx_data};
            idx     <= '0;
            icnt    <= '0;
            tcnt    <= '0;
            busy_q  <= 1'b1;
            ps2c_oe <= 1'b1;
            state   <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (icnt == INH_LAST) begin
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b1;
            state   <= S_RTS;
          end else begin
            icnt <= icnt + 1'b1;
          end
        end
        S_RTS: begin
          tcnt <= tcnt + 1'b1;
          if (tcnt == TO_LAST) begin
            state   <= S_ERROR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            ps2d_oe <= 1'b0;
          end else if (fall) begin
            // Shift order: d0..d7, parity, then stop (sh[0]=1 releases).
            ps2d_oe <= ~sh[0];
            sh      <= {1'b1, sh[9:1]};
            idx     <= idx + 1'b1;
            if (idx == 4'd9) state <= S_ACK;
          end
        end
        S_ACK: begin
          tcnt <= tcnt + 1'b1;
          if (tcnt == TO_LAST) begin
            state  <= S_ERROR;
            err_q  <= 1'b1;
            busy_q <= 1'b0;
          end else if (fall) begin
`ifdef PS2TX_ACK_CHECK_EN
            if (d_s) begin
              state  <= S_ERROR;
              err_q  <= 1'b1;
              busy_q <= 1'b0;
            end else begin
              state <= S_WAIT_IDLE;
            end
`else
            state <= S_WAIT_IDLE;
`endif
          end
        end
        S_WAIT_IDLE: begin
          tcnt <= tcnt + 1'b1;
          if (tcnt == TO_LAST) begin
            state  <= S_ERROR;
            err_q  <= 1'b1;
            busy_q <= 1'b0;
          end else if (d_s && c_filt) begin
            state  <= S_DONE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Directed bench: device model clocks frames, checks bits, ACK, timeout.
`timescale 1ns/1ps
module tb_ps2_host_transmitter;
  localparam int HALF = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic ps2c_oe, ps2d_oe;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  wire  ps2c_line = ~(ps2c_oe | dev_clk_low);
  wire  ps2d_line = ~(ps2d_oe | dev_dat_low);

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int bad_cnt = 0;

  ps2_host_transmitter_if hif ();

  ps2_host_transmitter #(
    .INHIBIT_CYCLES(5000),
    .TIMEOUT_CYCLES(2000),
    .FILTER_LEN(8)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .host    (hif),
    .ps2c_in (ps2c_line),
    .ps2d_in (ps2d_line),
    .ps2c_oe (ps2c_oe),
    .ps2d_oe (ps2d_oe)
  );

  always #10 clock = ~clock;

  always @(negedge clock) begin
    if (hif.tx_done === 1'b1) done_cnt <= done_cnt + 1;
    if (hif.tx_error === 1'b1) err_cnt <= err_cnt + 1;
    if ((hif.tx_done === 1'b1 || hif.tx_error === 1'b1)
        && hif.busy !== 1'b0) bad_cnt <= bad_cnt + 1;
    if (hif.tx_done === 1'b1 && hif.tx_error === 1'b1)
      bad_cnt <= bad_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_tx(input logic [7:0] d, input bit poke,
                          output int n);
    @(negedge clock);
    hif.tx_data = d;
    hif.start   = 1'b1;
    @(negedge clock);
    hif.start = 1'b0;
    n = 0;
    while (ps2c_oe === 1'b1 && n < 6000) begin
      n++;
      if (poke && n == 100) begin
        hif.start   = 1'b1;
        hif.tx_data = ~d;
      end else begin
        hif.start = 1'b0;
      end
      @(negedge clock);
    end
    hif.start = 1'b0;
  endtask

  task automatic dev_frame(input int nfalls, input bit ack_low,
                           output logic [10:0] bits);
    bits = '0;
    for (int k = 0; k < nfalls; k++) begin
      repeat (HALF) @(negedge clock);
      if (k < 11) bits[k] = ps2d_line;
      if (k == 10 && ack_low) dev_dat_low = 1'b1;
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clock);
      dev_clk_low = 1'b0;
    end
    repeat (HALF) @(negedge clock);
    dev_dat_low = 1'b0;
  endtask

  task automatic run_ok(input string tag, input logic [7:0] d,
                        input logic [10:0] exp_bits);
    int n, d0, e0;
    logic [10:0] bits;
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(d, 1'b0, n);
    chk({tag, "_rts_data"}, 32'(ps2d_oe), 32'd1);
    dev_frame(11, 1'b1, bits);
    repeat (20) @(negedge clock);
    chk({tag, "_bits"}, 32'(bits), 32'(exp_bits));
    chk({tag, "_done"}, done_cnt - d0, 32'd1);
    chk({tag, "_err"}, err_cnt - e0, 32'd0);
    chk({tag, "_busy"}, 32'(hif.busy), 32'd0);
  endtask

  initial begin
    int n, n2, d0, e0;
    logic [10:0] bits;
    hif.start   = 1'b0;
    hif.tx_data = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_c_oe", 32'(ps2c_oe), 32'd0);
    chk("rst_d_oe", 32'(ps2d_oe), 32'd0);
    chk("rst_busy", 32'(hif.busy), 32'd0);
    chk("rst_done", 32'(hif.tx_done), 32'd0);
    chk("rst_err", 32'(hif.tx_error), 32'd0);

    // 0xED: inhibit length, frame bits and pulses.
    d0 = done_cnt;
    start_tx(8'hED, 1'b0, n);
    chk("ed_inhibit_len", n, 5000);
    chk("ed_rts_data", 32'(ps2d_oe), 32'd1);
    chk("ed_rts_clk", 32'(ps2c_oe), 32'd0);
    dev_frame(11, 1'b1, bits);
    repeat (20) @(negedge clock);
    chk("ed_bits", 32'(bits), 32'h7DA);
    chk("ed_done", done_cnt - d0, 32'd1);
    chk("ed_busy", 32'(hif.busy), 32'd0);
    chk("ed_c_oe", 32'(ps2c_oe), 32'd0);
    chk("ed_d_oe", 32'(ps2d_oe), 32'd0);

    run_ok("ff", 8'hFF, 11'h7FE);
    run_ok("zero", 8'h00, 11'h600);

    // Device answers with ACK high.
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'h01, 1'b0, n);
    dev_frame(11, 1'b0, bits);
    repeat (20) @(negedge clock);
    chk("nack_bits", 32'(bits), 32'h402);
`ifdef PS2TX_ACK_CHECK_EN
    chk("nack_err", err_cnt - e0, 32'd1);
    chk("nack_done", done_cnt - d0, 32'd0);
`else
    chk("nack_err", err_cnt - e0, 32'd0);
    chk("nack_done", done_cnt - d0, 32'd1);
`endif
    chk("nack_c_oe", 32'(ps2c_oe), 32'd0);
    chk("nack_d_oe", 32'(ps2d_oe), 32'd0);

    // Silent device: timeout from RTS entry.
    e0 = err_cnt;
    start_tx(8'h5A, 1'b0, n);
    n2 = 0;
    while (hif.tx_error !== 1'b1 && n2 < 3000) begin
      @(negedge clock);
      n2++;
    end
    chk("to_cycles", n2, 2000);
    chk("to_c_oe", 32'(ps2c_oe), 32'd0);
    chk("to_d_oe", 32'(ps2d_oe), 32'd0);
    chk("to_busy", 32'(hif.busy), 32'd0);
    repeat (5) @(negedge clock);
    chk("to_err_pulses", err_cnt - e0, 32'd1);

    // Reset once bit index reaches 4.
    start_tx(8'h00, 1'b0, n);
    dev_frame(4, 1'b0, bits);
    chk("mid_d_oe", 32'(ps2d_oe), 32'd1);
    chk("mid_busy", 32'(hif.busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_c_oe", 32'(ps2c_oe), 32'd0);
    chk("midrst_d_oe", 32'(ps2d_oe), 32'd0);
    chk("midrst_busy", 32'(hif.busy), 32'd0);
    repeat (5) @(negedge clock);

    // Second start while busy is ignored.
    d0 = done_cnt;
    start_tx(8'hA5, 1'b1, n);
    chk("poke_inhibit_len", n, 5000);
    dev_frame(11, 1'b1, bits);
    repeat (20) @(negedge clock);
    chk("poke_bits", 32'(bits), 32'h74A);
    chk("poke_done", done_cnt - d0, 32'd1);

    // Short ps2c glitch must not shift a bit out.
    d0 = done_cnt;
    start_tx(8'h81, 1'b0, n);
    dev_clk_low = 1'b1;
    repeat (3) @(negedge clock);
    dev_clk_low = 1'b0;
    repeat (20) @(negedge clock);
    chk("glitch_d_oe", 32'(ps2d_oe), 32'd1);
    dev_frame(11, 1'b1, bits);
    repeat (20) @(negedge clock);
    chk("glitch_bits", 32'(bits), 32'h702);
    chk("glitch_done", done_cnt - d0, 32'd1);

    chk("pulse_overlap", bad_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
